signed_divider_32by16: RTL and testbench

// - Sequential signed divider: two's-complement N_W-bit dividend / D_W-bit divisor -> N_W-bit quotient, D_W-bit remainder.
// - Inverse companion of the 16x16 signed multiplier. Used by the Gaussian generator datapath (Box-Muller normalisation/scaling).
// - Restoring division on magnitudes: one quotient bit per clock, sign fix-up at the end. Start/busy/done handshake.

---
 rtl/grng_arith_pkg.sv | 32 +++
 rtl/signed_divider_32by16_if.sv | 36 +++
 rtl/sign_mag_conv.sv | 26 ++
 rtl/signed_divider_32by16.sv | 225 ++++++++++++++++++++++
 tb/tb_signed_divider_32by16.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grng_arith_pkg.sv
// ---------------------------------------------------------------------------
// grng_arith_pkg
// Shared definitions for the Gaussian generator arithmetic blocks (signed
// divider and signed multiplier).
//   - div_state_t      : divider FSM state encoding
//   - DEF_N_W, DEF_D_W : default datapath widths; DEF_D_W is also the
//                        multiplier operand width
//   - sat_pos, sat_neg : two's-complement saturation values for a given width
// ---------------------------------------------------------------------------
package grng_arith_pkg;

    localparam int DEF_N_W = 32;
    localparam int DEF_D_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } div_state_t;

    // Largest positive value of a w-bit two's-complement number (w <= 64).
    function automatic logic [63:0] sat_pos(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative value of a w-bit two's-complement number, as a w-bit
    // pattern in the low bits (w <= 64).
    function automatic logic [63:0] sat_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/signed_divider_32by16_if.sv
// ---------------------------------------------------------------------------
// signed_divider_32by16_if
// Request/result bundle of the signed divider.
//   start, dividend, divisor           : request (master -> slave)
//   busy, done, quotient, remainder,
//   div_by_zero, overflow               : status/result (slave -> master)
// Modports: master (requester), slave (divider).
// ---------------------------------------------------------------------------
interface signed_divider_32by16_if
    import grng_arith_pkg::*;
#(
    parameter int N_W = DEF_N_W,
    parameter int D_W = DEF_D_W
) ();

    logic           start;
    logic [N_W-1:0] dividend;
    logic [D_W-1:0] divisor;
    logic           busy;
    logic           done;
    logic [N_W-1:0] quotient;
    logic [D_W-1:0] remainder;
    logic           div_by_zero;
    logic           overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/sign_mag_conv.sv
// ---------------------------------------------------------------------------
// sign_mag_conv
// Two's complement <-> sign + magnitude conversion, both directions being a
// conditional negate:
//   - to magnitude  : value = two's-complement number, negate = its MSB;
//                     result = |value| as a W-bit unsigned number (the most
//                     negative input maps to 2^(W-1), which still fits).
//   - to two's comp : value = magnitude, negate = sign; result = signed value.
// Ports:
//   value  in  W  operand
//   negate in  1  1 = return -value (mod 2^W), 0 = pass through
//   result out W  converted value
// ---------------------------------------------------------------------------
module sign_mag_conv #(
    parameter int W = 16
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    always_comb begin
        result = negate ? (~value + W'(1)) : value;
    end

endmodule

// File: rtl/signed_divider_32by16.sv
// ---------------------------------------------------------------------------
// signed_divider_32by16
// Sequential signed divider: N_W-bit dividend / D_W-bit divisor, restoring
// division on magnitudes, one quotient bit per clock, sign fix-up at the end.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high
//   bus    slave modport of signed_divider_32by16_if
//            start/dividend/divisor sampled in IDLE only
//            busy high while not IDLE, done one-cycle pulse
//            quotient/remainder/div_by_zero/overflow held until next done
// Build option: define DIVIDER_ROUND_EN to round the quotient to nearest
// (half away from zero) instead of truncating toward zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands latched as magnitudes + signs
// ST_CALC | N_W restoring steps, MSB first, one per clock
// ST_SIGN | apply signs / saturation, write results, pulse done
// ---------------------------------------------------------------------------
module signed_divider_32by16
    import grng_arith_pkg::*;
#(
    parameter int N_W = DEF_N_W,
    parameter int D_W = DEF_D_W
) (
    input  logic                   clk,
    input  logic                   reset,
    signed_divider_32by16_if.slave bus
);

    localparam int             CNT_W     = $clog2(N_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_W - 1);
    localparam logic [N_W-1:0] Q_SAT_POS = N_W'(sat_pos(N_W));
    localparam logic [N_W-1:0] Q_SAT_NEG = N_W'(sat_neg(N_W));

    div_state_t       state;
    div_state_t       state_nxt;
    logic [CNT_W-1:0] count;

    // q_sr starts as |dividend|; each step shifts one dividend bit out of the
    // top and one quotient bit into the bottom, so after N_W steps it holds
    // the quotient magnitude.
    logic [N_W-1:0]   q_sr;
    logic [D_W-1:0]   rem_mag;
    logic [D_W-1:0]   div_mag;
    logic             sign_n;
    logic             sign_d;
    logic             dz_r;
    logic             ovf_r;

    logic             busy_c;
    logic             done_q;
    logic [N_W-1:0]   quotient_q;
    logic [D_W-1:0]   remainder_q;
    logic             div_by_zero_q;
    logic             overflow_q;

    logic [N_W-1:0]   dividend_mag;
    logic [D_W-1:0]   divisor_mag;

    // Restoring step. The stored partial remainder is always < |divisor|, so
    // it fits D_W bits; after the shift it needs D_W+1 bits, and the
    // subtraction result is known to be < |divisor| again, so its low D_W
    // bits are exact.
    logic [D_W:0]     shifted;
    logic             step_ge;
    logic [D_W-1:0]   rem_nxt;

    logic [N_W-1:0]   q_mag_fix;
    logic [D_W-1:0]   rem_fix;
    logic [N_W-1:0]   quot_tc;
    logic [D_W-1:0]   rem_tc;

    // ---------------------------------------------------------------- input
    sign_mag_conv #(.W(N_W)) u_conv_dividend (
        .value  (bus.dividend),
        .negate (bus.dividend[N_W-1]),
        .result (dividend_mag)
    );

    sign_mag_conv #(.W(D_W)) u_conv_divisor (
        .value  (bus.divisor),
        .negate (bus.divisor[D_W-1]),
        .result (divisor_mag)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.divisor == '0) ? ST_SIGN : ST_CALC;
                end
            end
            ST_CALC: begin
                if (count == LAST_STEP) begin
                    state_nxt = ST_SIGN;
                end
            end
            ST_SIGN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_c = (state != ST_IDLE);
    end

    // ---------------------------------------------------------------- step
    always_comb begin
        shifted = {rem_mag, q_sr[N_W-1]};
        step_ge = (shifted >= {1'b0, div_mag});
        rem_nxt = step_ge ? (shifted[D_W-1:0] - div_mag) : shifted[D_W-1:0];
    end

    // ---------------------------------------------------------------- fix-up
`ifdef DIVIDER_ROUND_EN
    // Round half away from zero on magnitudes. The adjusted remainder
    // rem_mag - div_mag is negative (wraps in D_W bits); negating it with the
    // dividend sign below keeps remainder = dividend - quotient*divisor.
    logic round_up;

    always_comb begin
        round_up  = ({rem_mag, 1'b0} >= {1'b0, div_mag});
        q_mag_fix = q_sr + N_W'(round_up);
        rem_fix   = round_up ? (rem_mag - div_mag) : rem_mag;
    end
`else
    always_comb begin
        q_mag_fix = q_sr;
        rem_fix   = rem_mag;
    end
`endif

    sign_mag_conv #(.W(N_W)) u_conv_quotient (
        .value  (q_mag_fix),
        .negate (sign_n ^ sign_d),
        .result (quot_tc)
    );

    sign_mag_conv #(.W(D_W)) u_conv_remainder (
        .value  (rem_fix),
        .negate (sign_n),
        .result (rem_tc)
    );

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            q_sr          <= '0;
            rem_mag       <= '0;
            div_mag       <= '0;
            sign_n        <= 1'b0;
            sign_d        <= 1'b0;
            dz_r          <= 1'b0;
            ovf_r         <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        q_sr    <= dividend_mag;
                        div_mag <= divisor_mag;
                        rem_mag <= '0;
                        count   <= '0;
                        sign_n  <= bus.dividend[N_W-1];
                        sign_d  <= bus.divisor[D_W-1];
                        dz_r    <= (bus.divisor == '0);
                        // Only -2^(N_W-1) / -1 has a quotient outside range.
                        ovf_r   <= (bus.dividend == Q_SAT_NEG) && (bus.divisor == '1);
                    end
                end
                ST_CALC: begin
                    q_sr    <= {q_sr[N_W-2:0], step_ge};
                    rem_mag <= rem_nxt;
                    count   <= count + CNT_W'(1);
                end
                ST_SIGN: begin
                    done_q        <= 1'b1;
                    div_by_zero_q <= dz_r;
                    overflow_q    <= ovf_r;
                    if (dz_r) begin
                        quotient_q <= sign_n ? Q_SAT_NEG : Q_SAT_POS;
                    end else if (ovf_r) begin
                        quotient_q <= Q_SAT_POS;
                    end else begin
                        quotient_q <= quot_tc;
                    end
                    remainder_q <= (dz_r || ovf_r) ? '0 : rem_tc;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.busy        = busy_c;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_signed_divider_32by16.sv
// ---------------------------------------------------------------------------
// tb_signed_divider_32by16
// Self-checking bench for signed_divider_32by16. Expected results come from
// a behavioural model using plain integer division (truncating toward zero),
// with rounding applied when DIVIDER_ROUND_EN is defined.
// ---------------------------------------------------------------------------
module tb_signed_divider_32by16;

    typedef struct packed {
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
    } res_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    signed_divider_32by16_if #(.N_W(32), .D_W(16)) bus ();

    signed_divider_32by16 #(.N_W(32), .D_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t ref_div(input logic [31:0] n_u, input logic [15:0] d_u);
        res_t   res;
        longint n;
        longint d;
        longint q;
        longint r;
        n       = longint'($signed(n_u));
        d       = longint'($signed(d_u));
        res.dz  = 1'b0;
        res.ovf = 1'b0;
        if (d == 0) begin
            res.dz = 1'b1;
            res.q  = (n < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            res.r  = 16'h0000;
        end else if (n_u == 32'h8000_0000 && d_u == 16'hFFFF) begin
            res.ovf = 1'b1;
            res.q   = 32'h7FFF_FFFF;
            res.r   = 16'h0000;
        end else begin
            q = n / d;
            r = n - q * d;
`ifdef DIVIDER_ROUND_EN
            if (2 * ((r < 0) ? -r : r) >= ((d < 0) ? -d : d)) begin
                q = q + (((n < 0) != (d < 0)) ? -1 : 1);
                r = n - q * d;
            end
`endif
            res.q = q[31:0];
            res.r = r[15:0];
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request now, let the next rising edge take it, then scramble
    // the operands so a DUT that fails to latch them is caught.
    task automatic launch(input logic [31:0] n, input logic [15:0] d);
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom();
        bus.divisor  = 16'($urandom());
    endtask

    // Returns on the negedge where done is seen; lat = edges after the start
    // edge, busy_cnt = busy samples before done.
    task automatic wait_done(output int lat, output int busy_cnt, output bit got);
        lat      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                @(posedge clk);
                lat++;
            end
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] n, input logic [15:0] d,
                             input bit pulse_chk, input bit immediate);
        res_t e;
        int   lat;
        int   bc;
        bit   got;
        int   exp_lat;
        e       = ref_div(n, d);
        exp_lat = (d == 16'd0) ? 1 : 33;
        if (!immediate) @(negedge clk);
        launch(n, d);
        wait_done(lat, bc, got);
        check($sformatf("%s done_seen", tag), 32'(got), 32'd1);
        check($sformatf("%s quotient", tag), bus.quotient, e.q);
        check($sformatf("%s remainder", tag), 32'(bus.remainder), 32'(e.r));
        check($sformatf("%s div_by_zero", tag), 32'(bus.div_by_zero), 32'(e.dz));
        check($sformatf("%s overflow", tag), 32'(bus.overflow), 32'(e.ovf));
        check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s busy_cycles", tag), 32'(bc), 32'(exp_lat));
        check($sformatf("%s busy_at_done", tag), 32'(bus.busy), 32'd0);
        if (pulse_chk) begin
            @(negedge clk);
            check($sformatf("%s done_single", tag), 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        int          lat;
        int          bc;
        bit          got;
        int          extra;
        logic [31:0] n;
        logic [15:0] d;
        int          mode;

        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset quotient", bus.quotient, 32'd0);
        check("reset remainder", 32'(bus.remainder), 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);

        // Directed cases
        run_check("1000/7", 32'd1000, 16'd7, 1'b1, 1'b0);
`ifdef DIVIDER_ROUND_EN
        check("1000/7 const q", bus.quotient, 32'd143);
        check("1000/7 const r", 32'(bus.remainder), 32'h0000_FFFF);
`else
        check("1000/7 const q", bus.quotient, 32'd142);
        check("1000/7 const r", 32'(bus.remainder), 32'd6);
`endif
        run_check("-1000/7", 32'hFFFF_FC18, 16'd7, 1'b1, 1'b0);
        run_check("1000/-7", 32'd1000, 16'hFFF9, 1'b1, 1'b0);
        run_check("ovf", 32'h8000_0000, 16'hFFFF, 1'b1, 1'b0);
        check("ovf const q", bus.quotient, 32'h7FFF_FFFF);
        run_check("5/0", 32'd5, 16'd0, 1'b1, 1'b0);
        check("5/0 const q", bus.quotient, 32'h7FFF_FFFF);
        run_check("-5/0", 32'hFFFF_FFFB, 16'd0, 1'b1, 1'b0);
        check("-5/0 const q", bus.quotient, 32'h8000_0000);
        run_check("20/8", 32'd20, 16'd8, 1'b1, 1'b0);
        run_check("19/8", 32'd19, 16'd8, 1'b1, 1'b0);
        run_check("-4/7", 32'hFFFF_FFFC, 16'd7, 1'b1, 1'b0);
        run_check("min/-32768", 32'h8000_0000, 16'h8000, 1'b1, 1'b0);
        run_check("max/1", 32'h7FFF_FFFF, 16'd1, 1'b1, 1'b0);
        run_check("0/-3", 32'd0, 16'hFFFD, 1'b1, 1'b0);

        // start while busy is ignored
        @(negedge clk);
        launch(32'd1000, 16'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 16'd3;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done(lat, bc, got);
        check("busy_start done_seen", 32'(got), 32'd1);
        check("busy_start quotient", bus.quotient, ref_div(32'd1000, 16'd7).q);
        check("busy_start remainder", 32'(bus.remainder), 32'(ref_div(32'd1000, 16'd7).r));
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("busy_start no_second_done", 32'(extra), 32'd0);

        // reset mid-operation aborts, clears outputs, no done
        launch(32'd12345, 16'd11);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort done", 32'(bus.done), 32'd0);
        check("abort quotient", bus.quotient, 32'd0);
        check("abort remainder", 32'(bus.remainder), 32'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("abort no_done", 32'(extra), 32'd0);

        // back-to-back: second start on the done cycle
        run_check("b2b_a", 32'hFFFF_0000, 16'd300, 1'b0, 1'b0);
        run_check("b2b_b", 32'd65537, 16'hFF00, 1'b1, 1'b1);
        run_check("b2b_c", 32'd9, 16'd0, 1'b0, 1'b0);
        run_check("b2b_d", 32'hFFFF_FFF7, 16'd4, 1'b1, 1'b1);

        // Randomized operands
        for (int i = 0; i < 150; i++) begin
            mode = int'($urandom_range(0, 9));
            n    = $urandom();
            d    = 16'($urandom());
            if (mode == 0) d = 16'd0;
            else if (mode == 1) d = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'd1;
            else if (mode == 2) d = 16'h8000;
            else if (mode == 3) n = 32'h8000_0000;
            else if (mode == 4) d = 16'($urandom_range(1, 15));
            run_check("rand", n, d, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
